// File: rtl/prog_loader.sv
// UART program loader: assembles little-endian 32-bit words from a byte
// stream and writes them into the ICCM while holding the core in reset.
// Optional feature macro: PROG_LOADER_CHKSUM_EN adds an XOR checksum word
// after END_WORD that must match the running XOR of all written words.
module prog_loader #(
  parameter int unsigned ADDR_W      = 12,
  parameter logic [31:0] END_WORD    = 32'h0000_0FFF,
  parameter logic [31:0] TIMEOUT_CYC = 32'd200_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_i,
  input  logic              rx_dv_i,
  input  logic [7:0]        rx_byte_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              prog_rst_no,
  output logic              done_o,
  output logic              err_o
);

`ifdef PROG_LOADER_CHKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;
`endif

  state_t            state;
  logic              prog_q;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift_q;
  logic [31:0]       tmo_cnt;
  logic [ADDR_W-1:0] next_addr;
  logic              full_q;
`ifdef PROG_LOADER_CHKSUM_EN
  logic [31:0]       chk_xor;
`endif

  logic [31:0] word_c;
  logic        tmo_hit_c;
  logic        start_c;

  // Word currently completing (valid when the 4th byte is on rx_byte_i)
  assign word_c    = {rx_byte_i, shift_q};
  // A partial word has been idle for TIMEOUT_CYC cycles
  assign tmo_hit_c = (byte_cnt != 2'd0) && !rx_dv_i && (tmo_cnt >= TIMEOUT_CYC - 32'd1);
  // Load starts on prog_i level in IDLE, only on a fresh rising edge in ERROR
  assign start_c   = ((state == IDLE) && prog_i) ||
                     ((state == ERROR) && prog_i && !prog_q);

  // Loader FSM with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      prog_q      <= 1'b0;
      byte_cnt    <= 2'd0;
      shift_q     <= 24'd0;
      tmo_cnt     <= 32'd0;
      next_addr   <= '0;
      full_q      <= 1'b0;
      we_o        <= 1'b0;
      addr_o      <= '0;
      wdata_o     <= 32'd0;
      prog_rst_no <= 1'b1;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_xor     <= 32'd0;
`endif
    end else begin
      prog_q <= prog_i;
      we_o   <= 1'b0;
      if (start_c) begin
        state       <= RECV;
        byte_cnt    <= 2'd0;
        tmo_cnt     <= 32'd0;
        next_addr   <= '0;
        full_q      <= 1'b0;
        addr_o      <= '0;
        done_o      <= 1'b0;
        err_o       <= 1'b0;
        prog_rst_no <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
        chk_xor     <= 32'd0;
`endif
      end else begin
        case (state)
          RECV: begin
            if (!prog_i || tmo_hit_c) begin
              state <= ERROR;
              err_o <= 1'b1;
            end else if (rx_dv_i) begin
              tmo_cnt  <= 32'd0;
              byte_cnt <= byte_cnt + 2'd1;
              shift_q  <= word_c[31:8];
              if (byte_cnt == 2'd3) begin
                if (word_c == END_WORD) begin
`ifdef PROG_LOADER_CHKSUM_EN
                  state       <= CHECK;
`else
                  state       <= DONE;
                  done_o      <= 1'b1;
                  prog_rst_no <= 1'b1;
`endif
                end else if (full_q) begin
                  state <= ERROR;
                  err_o <= 1'b1;
                end else begin
                  we_o    <= 1'b1;
                  wdata_o <= word_c;
                  addr_o  <= next_addr;
`ifdef PROG_LOADER_CHKSUM_EN
                  chk_xor <= chk_xor ^ word_c;
`endif
                  // Saturate instead of wrapping; the next word overflows
                  if (next_addr == {ADDR_W{1'b1}}) begin
                    full_q <= 1'b1;
                  end else begin
                    next_addr <= next_addr + ADDR_W'(1);
                  end
                end
              end
            end else if (byte_cnt != 2'd0) begin
              tmo_cnt <= tmo_cnt + 32'd1;
            end
          end
`ifdef PROG_LOADER_CHKSUM_EN
          CHECK: begin
            if (!prog_i || tmo_hit_c) begin
              state <= ERROR;
              err_o <= 1'b1;
            end else if (rx_dv_i) begin
              tmo_cnt  <= 32'd0;
              byte_cnt <= byte_cnt + 2'd1;
              shift_q  <= word_c[31:8];
              if (byte_cnt == 2'd3) begin
                if (word_c == chk_xor) begin
                  state       <= DONE;
                  done_o      <= 1'b1;
                  prog_rst_no <= 1'b1;
                end else begin
                  state <= ERROR;
                  err_o <= 1'b1;
                end
              end
            end else if (byte_cnt != 2'd0) begin
              tmo_cnt <= tmo_cnt + 32'd1;
            end
          end
`endif
          DONE: begin
            if (!prog_i) begin
              state <= IDLE;
            end
          end
          IDLE, ERROR: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed scenarios plus randomized
// loads checked against a word-list reference model.
module tb_prog_loader;

  localparam int          ADDR_W   = 2;
  localparam int          TMO      = 100;
  localparam int          CAP      = 1 << ADDR_W;
  localparam logic [31:0] END_WORD = 32'h0000_0FFF;
`ifdef PROG_LOADER_CHKSUM_EN
  localparam bit          CHK_ON   = 1'b1;
`else
  localparam bit          CHK_ON   = 1'b0;
`endif

  logic              clk_i;
  logic              rst_i;
  logic              prog_i;
  logic              rx_dv_i;
  logic [7:0]        rx_byte_i;
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;
  logic              prog_rst_no;
  logic              done_o;
  logic              err_o;

  int checks;
  int passes;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] words[$];

  prog_loader #(
    .ADDR_W      (ADDR_W),
    .END_WORD    (END_WORD),
    .TIMEOUT_CYC (32'(TMO))
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .prog_i      (prog_i),
    .rx_dv_i     (rx_dv_i),
    .rx_byte_i   (rx_byte_i),
    .we_o        (we_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .prog_rst_no (prog_rst_no),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Capture every ICCM write away from the active edge
  always @(negedge clk_i) begin
    if (we_o === 1'b1) begin
      cap_addr.push_back(32'(addr_o));
      cap_data.push_back(wdata_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv_i   = 1'b1;
    rx_byte_i = b;
    @(negedge clk_i);
    rx_dv_i   = 1'b0;
    rx_byte_i = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (gaps) tick(int'($urandom_range(0, 3)));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},   32'(we_o),        32'd0);
    check({tag, "_addr"}, 32'(addr_o),      32'd0);
    check({tag, "_data"}, wdata_o,          32'd0);
    check({tag, "_prst"}, 32'(prog_rst_no), 32'd1);
    check({tag, "_done"}, 32'(done_o),      32'd0);
    check({tag, "_err"},  32'(err_o),       32'd0);
  endtask

  // Drop prog_i, raise it again, and confirm the core is held in reset
  task automatic start_load(input string tag);
    prog_i = 1'b0;
    tick(2);
    cap_addr.delete();
    cap_data.delete();
    prog_i = 1'b1;
    tick(1);
    check({tag, "_start_prst"}, 32'(prog_rst_no), 32'd0);
    check({tag, "_start_done"}, 32'(done_o),      32'd0);
    check({tag, "_start_err"},  32'(err_o),       32'd0);
  endtask

  // Send words[0..n-1], END_WORD and (if enabled) the checksum; compare
  // the captured writes and final status against the word-list model
  task automatic run_load(input string tag, input int n, input logic [31:0] flip, input bit gaps);
    logic [31:0] x;
    int          n_wr;
    bit          exp_err;
    start_load(tag);
    n_wr = (n > CAP) ? CAP : n;
    x = 32'd0;
    for (int i = 0; i < n_wr; i++) x = x ^ words[i];
    exp_err = (n > CAP) || (CHK_ON && (flip != 32'd0));
    for (int i = 0; i < n; i++) send_word(words[i], gaps);
    send_word(END_WORD, gaps);
    if (CHK_ON) send_word(x ^ flip, gaps);
    tick(2);
    check({tag, "_nwr"}, 32'(cap_addr.size()), 32'(n_wr));
    for (int i = 0; i < n_wr && i < cap_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), cap_addr[i], 32'(i));
      check($sformatf("%s_data%0d", tag, i), cap_data[i], words[i]);
    end
    check({tag, "_err"},  32'(err_o),       32'(exp_err));
    check({tag, "_done"}, 32'(done_o),      32'(!exp_err));
    check({tag, "_prst"}, 32'(prog_rst_no), 32'(!exp_err));
    check({tag, "_we"},   32'(we_o),        32'd0);
  endtask

  initial begin
    int          n;
    logic [31:0] w;
    logic [31:0] flip;
    checks    = 0;
    passes    = 0;
    rst_i     = 1'b1;
    prog_i    = 1'b0;
    rx_dv_i   = 1'b0;
    rx_byte_i = 8'h00;
    tick(2);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick(1);

    // Single word then END
    words = '{32'h1234_5678};
    run_load("single", 1, 32'd0, 1'b0);

    // Leaving DONE keeps done_o and releases the core; bytes in IDLE ignored
    prog_i = 1'b0;
    tick(2);
    check("idle_done_hold", 32'(done_o),      32'd1);
    check("idle_prst",      32'(prog_rst_no), 32'd1);
    send_word(32'hDEAD_BEEF, 1'b0);
    tick(2);
    check("idle_ignore", 32'(cap_addr.size()), 32'd1);

    // Two words, good and bad checksum
    words = '{32'hA5A5_A5A5, 32'h0F0F_0F0F};
    run_load("chk_good", 2, 32'd0, 1'b0);
    run_load("chk_bad",  2, 32'd1, 1'b0);

    // Overflow: 5 words into a 4-word ICCM
    words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    run_load("ovf", 5, 32'd0, 1'b0);

    // Timeout inactive with no partial word, then fires after TMO idle cycles
    start_load("tmo");
    tick(TMO + 50);
    check("tmo_empty_err", 32'(err_o), 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    tick(TMO - 1);
    check("tmo_early_err", 32'(err_o), 32'd0);
    tick(1);
    check("tmo_err",  32'(err_o),            32'd1);
    check("tmo_prst", 32'(prog_rst_no),      32'd0);
    check("tmo_nwr",  32'(cap_addr.size()),  32'd0);

    // Abort by dropping prog_i mid-word
    start_load("abort");
    send_word(32'h0102_0304, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    prog_i = 1'b0;
    tick(2);
    check("abort_err",  32'(err_o),           32'd1);
    check("abort_prst", 32'(prog_rst_no),     32'd0);
    check("abort_nwr",  32'(cap_addr.size()), 32'd1);
    check("abort_data", cap_data[0],          32'h0102_0304);

    // Asynchronous reset after byte 2 of the second word
    start_load("mid_rst");
    send_word(32'hAABB_CCDD, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    #2;
    rst_i  = 1'b1;
    prog_i = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick(2);
    rst_i = 1'b0;
    tick(4);
    check("mid_rst_nwr", 32'(cap_addr.size()), 32'd1);
    words = '{32'hCAFE_0001, 32'hCAFE_0002};
    run_load("after_rst", 2, 32'd0, 1'b1);

    // Randomized loads with random inter-byte gaps
    for (int it = 0; it < 10; it++) begin
      n = int'($urandom_range(0, CAP + 1));
      words.delete();
      for (int i = 0; i < n; i++) begin
        do w = $urandom; while (w == END_WORD);
        words.push_back(w);
      end
      flip = ($urandom_range(0, 1) == 1) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
      run_load($sformatf("rnd%0d", it), n, flip, 1'b1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 12: ICCM word-address width.
REQ-002 Parameter END_WORD, default 32'h0000_0FFF: end-of-program marker word.
REQ-003 Parameter TIMEOUT_CYC, default 32'd200_000: maximum idle cycles allowed within a partial word.
REQ-004 Port clk_i  in  1: single clock; all logic samples on the rising edge.
REQ-005 Port rst_i  in  1: reset, asynchronous and active-high.
REQ-006 Port prog_i  in  1: programming-mode request, level-sensitive.
REQ-007 Port rx_dv_i  in  1: one-cycle strobe marking a valid received UART byte.
REQ-008 Port rx_byte_i  in  8: received byte, valid while rx_dv_i=1.
REQ-009 Port we_o  out  1: ICCM write enable, one-cycle pulse.
REQ-010 Port addr_o  out  ADDR_W: ICCM word address.
REQ-011 Port wdata_o  out  32: ICCM write data.
REQ-012 Port prog_rst_no  out  1: core reset, active-low; 0 holds the core in reset.
REQ-013 Port done_o  out  1: load completed successfully.
REQ-014 Port err_o  out  1: load failed (timeout, overflow or checksum).

Function
REQ-015 The FSM states SHALL be IDLE, RECV, CHECK, DONE and ERROR.
REQ-016 IDLE: prog_i=1 SHALL move the FSM to RECV and clear the byte count, word address, checksum, done_o and err_o.
REQ-017 prog_rst_no SHALL be 0 in RECV, CHECK and ERROR, and 1 in IDLE and DONE.
REQ-018 In RECV, each rx_dv_i SHALL shift rx_byte_i into a 32-bit assembly register, little-endian: the first byte fills bits [7:0].
REQ-019 On the 4th byte, if the assembled word does not equal END_WORD, the block SHALL drive we_o=1, wdata_o=word and addr_o=current address in the next cycle, then increment the address.
REQ-020 If the assembled word equals END_WORD, the block SHALL NOT write it and SHALL go to CHECK when CHKSUM is compiled in, otherwise to DONE.
REQ-021 A byte that arrives in the same cycle as a we_o pulse SHALL be accepted as byte 0 of the next word, with no loss.
REQ-022 Overflow: if 2^ADDR_W words are already written and another non-END word completes, the block SHALL issue no write and SHALL go to ERROR.
REQ-023 The word address SHALL never wrap.
REQ-024 Timeout: while 1 to 3 bytes of a word are held, TIMEOUT_CYC cycles without rx_dv_i SHALL cause a move to ERROR.
REQ-025 The timeout counter SHALL reset on every rx_dv_i and SHALL be inactive when the byte count is 0.
REQ-026 In DONE, done_o SHALL be 1; deasserting prog_i SHALL move the FSM to IDLE, and done_o SHALL hold at 1 until the next load starts.
REQ-027 In ERROR, err_o SHALL be 1 and the core SHALL stay in reset.
REQ-028 Only a new prog_i rising edge SHALL leave ERROR, moving the FSM to RECV.
REQ-029 Deasserting prog_i in RECV or CHECK SHALL abort the load: the FSM goes to ERROR and the partial word is discarded.
REQ-030 In IDLE and DONE, rx_dv_i SHALL be ignored.
REQ-031 we_o SHALL be 0 in every state except the single write cycle.

Reset
REQ-032 On rst_i=1 the FSM SHALL go to IDLE immediately, regardless of clk_i.
REQ-033 Reset values SHALL be: we_o=0, addr_o=0, wdata_o=0, prog_rst_no=1, done_o=0, err_o=0.
REQ-034 Reset values SHALL also be: byte count=0, timeout counter=0, checksum=0.
REQ-035 A reset in the middle of a load SHALL discard all progress, and no we_o pulse SHALL follow the reset edge.

Configuration
REQ-036 Macro PROG_LOADER_CHKSUM_EN SHALL compile the checksum feature in or out.
REQ-037 With PROG_LOADER_CHKSUM_EN defined, a running XOR of all written words SHALL be kept.
REQ-038 With the macro defined, the 4 bytes received after END_WORD form the expected checksum, little-endian, collected in CHECK.
REQ-039 A checksum match SHALL move the FSM to DONE, and a mismatch SHALL move it to ERROR.
REQ-040 The timeout and abort rules SHALL apply in CHECK.
REQ-041 Without PROG_LOADER_CHKSUM_EN, the CHECK state and the XOR logic SHALL be absent, and END_WORD SHALL go directly to DONE.

Verification
REQ-042 Rising prog_i, bytes 78 56 34 12, then FF 0F 00 00, macro off -> exactly one write: addr 0, data 0x12345678; then done_o=1 and prog_rst_no=1.
REQ-043 Macro on, words 0xA5A5A5A5 and 0x0F0F0F0F, then END_WORD, then checksum bytes AA AA AA AA -> two writes at addr 0 and addr 1, then done_o=1.
REQ-044 Same stimulus as REQ-043 with checksum bytes AB AA AA AA -> err_o=1 and prog_rst_no stays 0.
REQ-045 TIMEOUT_CYC=100, send 2 bytes, then wait 100 idle cycles -> err_o=1 and no we_o pulse.
REQ-046 ADDR_W=2, send 4 words then a 5th non-END word -> writes at addresses 0 to 3 only, then err_o=1.
REQ-047 Assert rst_i after byte 2 of a word -> all outputs at reset values and no write; a new prog_i edge then loads correctly from addr 0.
